// File: rtl/handshake_pkg.sv
// Shared definitions for elastic handshake buffers.
// Occupancy encoding for the 2-slot buffers and the default match-counter width.
package handshake_pkg;

  localparam int unsigned OCC_W = 2;

  localparam logic [OCC_W-1:0] EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] ONE   = 2'd1;
  localparam logic [OCC_W-1:0] FULL  = 2'd2;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage : handshake_pkg

// File: rtl/handshake_buffer_2slot.sv
// Two-entry registered elastic buffer (FIFO order) on valid/ready channels.
// Ports:
//   clk, rst (sync, active-low)
//   in_data/in_valid/in_ready    : upstream channel
//   out_data/out_valid/out_ready : downstream channel
// in_ready and out_valid come straight from flops, so neither channel's
// handshake inputs reach the other channel's handshake outputs combinationally.
module handshake_buffer_2slot
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  enq_c, deq_c;

  assign enq_c = in_valid && in_ready_q;
  assign deq_c = out_valid_q && out_ready;

  // Next-state: storage, pointers, occupancy and the registered handshake flags.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq_c) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({enq_c, deq_c})
      2'b10:   count_d = OCC_W'(count_q + 2'd1);
      2'b01:   count_d = OCC_W'(count_q - 2'd1);
      default: count_d = count_q;
    endcase

    // Flags precomputed from next occupancy so they are pure flop outputs.
    in_ready_d  = (count_d != FULL);
    out_valid_d = (count_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule : handshake_buffer_2slot

// File: rtl/handshake_eq_const.sv
// Equality-with-constant dataflow unit: each accepted input word produces a
// 1-bit token (ins == CONST_VALUE) through a 2-slot elastic buffer.
// Ports:
//   clk, rst (sync, active-low)
//   ins/ins_valid/ins_ready     : data input channel
//   outs/outs_valid/outs_ready  : 1-bit result channel
//   match_count                 : count of accepted matching tokens
// Build option: define HANDSHAKE_EQ_CONST_CNT_EN to build the match counter;
// otherwise match_count is tied to zero.
module handshake_eq_const
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] CONST_VALUE = 32'h3F41_4727,
  parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  match_count
);

  // Constant zero-extended or truncated to the data width.
  localparam logic [DATA_WIDTH-1:0] CONST_ADJ = DATA_WIDTH'(CONST_VALUE);

  logic eq_c;

  assign eq_c = (ins == CONST_ADJ);

  handshake_buffer_2slot #(
    .WIDTH (1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (eq_c),
    .in_valid  (ins_valid),
    .in_ready  (ins_ready),
    .out_data  (outs),
    .out_valid (outs_valid),
    .out_ready (outs_ready)
  );

`ifdef HANDSHAKE_EQ_CONST_CNT_EN
  logic                 enq_c;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;

  assign enq_c = ins_valid && ins_ready;

  // Counts at the accept edge, wrapping at 2^CNT_WIDTH.
  always_comb begin
    match_count_d = match_count_q;
    if (enq_c && eq_c) begin
      match_count_d = CNT_WIDTH'(match_count_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      match_count_q <= '0;
    end else begin
      match_count_q <= match_count_d;
    end
  end

  assign match_count = match_count_q;
`else
  assign match_count = '0;
`endif

endmodule : handshake_eq_const

// File: tb/tb_handshake_eq_const.sv
// Directed self-checking bench for handshake_eq_const.
module tb_handshake_eq_const;

  localparam logic [31:0] K = 32'h3F41_4727;
`ifdef HANDSHAKE_EQ_CONST_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        outs;
  logic        outs_valid;
  logic        outs_ready;
  logic [15:0] match_count;

  int total;
  int bad;
  int exp_mc;

  handshake_eq_const dut (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .outs        (outs),
    .outs_valid  (outs_valid),
    .outs_ready  (outs_ready),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_mc = 0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_mc = 0;
    rst = 1'b0;
    ins = K;
    ins_valid = 1'b1;
    outs_ready = 1'b1;

    // Reset held two cycles with a token offered.
    tick();
    tick();
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("rst_outs_valid", 32'(outs_valid), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_match_count", 32'(match_count), 32'd0);
    rst = 1'b1;
    ins_valid = 1'b0;
    tick();
    chk("post_rst_no_token", 32'(outs_valid), 32'd0);

    // Single matching token.
    ins = K;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    exp_mc += CNT_ON;
    chk("single_valid", 32'(outs_valid), 32'd1);
    chk("single_outs", 32'(outs), 32'd1);
    chk("single_mc", 32'(match_count), 32'(exp_mc));
    tick();
    chk("single_drained", 32'(outs_valid), 32'd0);

    // Back-to-back stream from a fresh reset.
    do_reset();
    begin
      logic [31:0] sv [4];
      logic        se [4];
      sv = '{32'h3F41_4727, 32'h0, 32'h3F41_4726, 32'h3F41_4727};
      se = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        ins = sv[i];
        ins_valid = 1'b1;
        tick();
        if (se[i]) exp_mc += CNT_ON;
        chk($sformatf("stream_valid_%0d", i), 32'(outs_valid), 32'd1);
        chk($sformatf("stream_outs_%0d", i), 32'(outs), 32'(se[i]));
        chk($sformatf("stream_ready_%0d", i), 32'(ins_ready), 32'd1);
      end
      ins_valid = 1'b0;
      chk("stream_mc", 32'(match_count), 32'(2 * CNT_ON));
      tick();
      chk("stream_drained", 32'(outs_valid), 32'd0);
    end

    // Backpressure: A=K, B=0, C=K offered with outs_ready low.
    outs_ready = 1'b0;
    ins = K;
    ins_valid = 1'b1;
    tick();
    exp_mc += CNT_ON;
    chk("bp_a_ready", 32'(ins_ready), 32'd1);
    chk("bp_a_outs", 32'(outs), 32'd1);
    ins = 32'h0;
    tick();
    chk("bp_b_full", 32'(ins_ready), 32'd0);
    chk("bp_b_hold", 32'(outs), 32'd1);
    ins = K;
    tick();
    chk("bp_c_blocked", 32'(ins_ready), 32'd0);
    chk("bp_c_hold", 32'(outs), 32'd1);
    chk("bp_c_mc", 32'(match_count), 32'(exp_mc));
    outs_ready = 1'b1;
    tick();
    chk("bp_drain_b", 32'(outs), 32'd0);
    chk("bp_ready_back", 32'(ins_ready), 32'd1);
    tick();
    exp_mc += CNT_ON;
    ins_valid = 1'b0;
    chk("bp_drain_c", 32'(outs), 32'd1);
    chk("bp_drain_c_valid", 32'(outs_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(outs_valid), 32'd0);
    chk("bp_mc", 32'(match_count), 32'(exp_mc));

    // Steady enq+deq at occupancy 1; alternating results expose loss or duplication.
    ins = K;
    ins_valid = 1'b1;
    tick();
    exp_mc += CNT_ON;
    for (int i = 1; i <= 10; i++) begin
      logic eb;
      eb = (i % 2 == 0);
      ins = eb ? K : 32'(i);
      tick();
      if (eb) exp_mc += CNT_ON;
      chk($sformatf("sim_valid_%0d", i), 32'(outs_valid), 32'd1);
      chk($sformatf("sim_ready_%0d", i), 32'(ins_ready), 32'd1);
      chk($sformatf("sim_outs_%0d", i), 32'(outs), 32'(eb));
    end
    ins_valid = 1'b0;
    tick();
    chk("sim_drained", 32'(outs_valid), 32'd0);
    chk("sim_mc", 32'(match_count), 32'(exp_mc));

    // Reset while full discards both buffered results.
    outs_ready = 1'b0;
    ins = K;
    ins_valid = 1'b1;
    tick();
    tick();
    chk("rfull_full", 32'(ins_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("rfull_valid", 32'(outs_valid), 32'd0);
    chk("rfull_ready", 32'(ins_ready), 32'd1);
    chk("rfull_outs", 32'(outs), 32'd0);
    chk("rfull_mc", 32'(match_count), 32'd0);
    rst = 1'b1;
    ins_valid = 1'b0;
    outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rfull_none_%0d", i), 32'(outs_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_handshake_eq_const
